// File: rtl/timer_device.sv
`default_nettype none
// ============================================================================
// Module      : timer_device
// Description : Memory-mapped countdown timer on the CPU data bus. Responds to
//               word load/store cycles selected by the address bridge and
//               raises one hardware-interrupt line when the count expires.
//               Register map (addr[3:2]):
//                 0x0 CTRL   rw  [0]=EN [2:1]=MODE (01 auto-reload, else one-shot) [3]=IM
//                 0x4 PRESET rw  reload value
//                 0x8 COUNT  ro  current count
//                 0xC        ro  reads 0
// Ports       : clk     - system clock, rising edge
//               reset   - asynchronous active-low reset
//               sel     - bridge select for this timer
//               addr    - byte address (only [3:2] decoded)
//               byteen  - store byte enables (only full-word stores write)
//               wdata   - store data
//               rdata   - combinational load data (0 when not selected)
//               irq     - interrupt request (IM & flag)
// Revision    : 1.0 - initial release
// ============================================================================
module timer_device #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] CTRL_MASK = 32'h0000_000F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] c_REG_CTRL   = 2'b00;
    localparam logic [1:0] c_REG_PRESET = 2'b01;
    localparam logic [1:0] c_REG_COUNT  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        ctrl_q, ctrl_d;
    logic [WIDTH-1:0]   preset_q, preset_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               flag_q, flag_d;

    logic w_we;
    logic w_ctrl_we;
    logic w_preset_we;
    logic w_en;
    logic w_im;
    logic w_reload;
    logic w_unused_addr;

    // Sub-word stores trap in the CPU, so only full-word stores are honoured.
    assign w_we        = sel && (byteen == 4'hF);
    assign w_ctrl_we   = w_we && (addr[3:2] == c_REG_CTRL);
    assign w_preset_we = w_we && (addr[3:2] == c_REG_PRESET);

    assign w_en     = ctrl_q[0];
    assign w_reload = (ctrl_q[2:1] == 2'b01);
    assign w_im     = ctrl_q[3];

    // Base address is decoded by the bridge; these bits are intentionally ignored.
    assign w_unused_addr = &{1'b0, addr[31:4], addr[1:0]};

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        case (state_q)
            S_IDLE: begin
                if (w_en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                flag_d  = 1'b0;         // auto-reload: makes irq a one-cycle pulse
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!w_en) begin
                    state_d = S_IDLE;
                end else if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    // PRESET of 0 or 1 both expire here
                    count_d = '0;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                flag_d = 1'b1;
                if (w_reload) begin
                    state_d = S_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!w_im) begin
            flag_d = 1'b0;
        end

        // PRESET only takes effect at the next LOAD.
        if (w_preset_we) begin
            preset_d = wdata[WIDTH-1:0];
        end

        // A software CTRL write overrides whatever the FSM decided this edge.
        if (w_ctrl_we) begin
            ctrl_d = wdata & CTRL_MASK;
            flag_d = 1'b0;
            if (!wdata[0]) begin
                state_d = S_IDLE;
                count_d = count_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[3:2])
                c_REG_CTRL:   rdata = ctrl_q;
                c_REG_PRESET: rdata = 32'(preset_q);
                c_REG_COUNT:  rdata = 32'(count_q);
                default:      rdata = '0;
            endcase
        end
    end

    assign irq = w_im & flag_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_device.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_device
// Description : Directed self-checking bench for timer_device. Inputs are
//               driven on the falling clock edge; outputs are sampled between
//               rising edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_device;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    timer_device #(
        .WIDTH     (32),
        .CTRL_MASK (32'h0000_000F)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        sel    = 1'b1;
        addr   = a;
        byteen = 4'h0;
        #1;
        d   = rdata;
        sel = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    // Store: the rising edge inside this task is the write edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
        sel    = 1'b1;
        addr   = a;
        wdata  = d;
        byteen = be;
        @(negedge clk);
        sel    = 1'b0;
        byteen = 4'h0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic seen;
        reset  = 1'b0;
        sel    = 1'b0;
        addr   = 32'h0;
        byteen = 4'h0;
        wdata  = 32'h0;

        // ---------------- reset state ----------------
        #1;
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_nosel", rdata, 32'h0);
        chk_rd("rst_ctrl", 32'h0, 32'h0);
        chk_rd("rst_preset", 32'h4, 32'h0);
        chk_rd("rst_count", 32'h8, 32'h0);
        tick(2);
        reset = 1'b1;

        // ---------------- one-shot, PRESET=5 ----------------
        wr(32'h4, 32'd5);
        wr(32'h0, 32'h9);                     // write edge E0
        tick(2);                              // after E2: LOAD done
        chk_rd("os_cnt5", 32'h8, 32'd5);
        for (int k = 4; k >= 0; k--) begin
            tick(1);
            chk_rd($sformatf("os_cnt%0d", k), 32'h8, 32'(k));
        end
        chk("os_irq_pre", {31'b0, irq}, 32'h0);   // after E7
        tick(1);
        chk("os_irq_rise", {31'b0, irq}, 32'h1);  // after E8
        tick(3);
        chk("os_irq_held", {31'b0, irq}, 32'h1);
        chk_rd("os_ctrl", 32'h0, 32'h8);
        wr(32'h0, 32'h0);
        chk("os_irq_clr", {31'b0, irq}, 32'h0);

        // ---------------- bus rules ----------------
        wr(32'h8, 32'h1234);
        chk_rd("bus_count_ro", 32'h8, 32'h0);
        wr(32'h4, 32'h0000_AAAA, 4'b0011);
        chk_rd("bus_partial", 32'h4, 32'd5);
        chk_rd("bus_reg_c", 32'hC, 32'h0);
        sel  = 1'b0;
        addr = 32'h4;
        #1;
        chk("bus_nosel", rdata, 32'h0);
        wr(32'h0, 32'hFFFF_FFF0);
        chk_rd("bus_ctrl_mask", 32'h0, 32'h0);

        // ---------------- auto-reload, PRESET=3 ----------------
        wr(32'h4, 32'd3);
        wr(32'h0, 32'hB);                     // E0
        for (int k = 1; k <= 17; k++) begin
            tick(1);
            chk($sformatf("ar_irq_e%0d", k), {31'b0, irq},
                {31'b0, (k >= 6) && (((k - 6) % 5) == 0)});
        end
        wr(32'h0, 32'h3);                     // IM off, still running
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            seen = seen | irq;
        end
        chk("ar_im_off", {31'b0, seen}, 32'h0);
        wr(32'h0, 32'h0);

        // ---------------- CTRL write EN=0 on the expiring edge ----------------
        wr(32'h4, 32'd3);
        wr(32'h0, 32'h9);                     // E0
        tick(4);                              // after E4: COUNT=1
        chk_rd("sim_cnt1", 32'h8, 32'd1);
        wr(32'h0, 32'h8);                     // E5 would have gone to INT
        chk_rd("sim_cnt_hold", 32'h8, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            seen = seen | irq;
        end
        chk("sim_no_irq", {31'b0, seen}, 32'h0);
        chk_rd("sim_cnt_idle", 32'h8, 32'd1);
        chk_rd("sim_ctrl", 32'h0, 32'h8);

        // ---------------- PRESET=0 ----------------
        wr(32'h0, 32'h0);
        wr(32'h4, 32'd0);
        wr(32'h0, 32'h9);                     // E0
        tick(3);
        chk("p0_irq_e3", {31'b0, irq}, 32'h0);
        tick(1);
        chk("p0_irq_e4", {31'b0, irq}, 32'h1);

        // ---------------- PRESET rewritten mid-count ----------------
        wr(32'h0, 32'h0);
        wr(32'h4, 32'd4);
        wr(32'h0, 32'h9);                     // E0
        tick(3);
        chk_rd("mid_cnt3", 32'h8, 32'd3);
        wr(32'h4, 32'd7);                     // E4
        chk_rd("mid_cnt2", 32'h8, 32'd2);
        tick(1);
        chk_rd("mid_cnt1", 32'h8, 32'd1);
        tick(1);
        chk_rd("mid_cnt0", 32'h8, 32'd0);
        chk("mid_irq_e6", {31'b0, irq}, 32'h0);
        tick(1);
        chk("mid_irq_e7", {31'b0, irq}, 32'h1);
        chk_rd("mid_preset", 32'h4, 32'd7);
        wr(32'h0, 32'h0);
        wr(32'h0, 32'h9);
        tick(2);
        chk_rd("mid_next_load", 32'h8, 32'd7);

        // ---------------- async reset mid-count ----------------
        wr(32'h0, 32'h0);
        wr(32'h4, 32'd10);
        wr(32'h0, 32'hB);                     // E0
        tick(4);
        chk_rd("ra_cnt8", 32'h8, 32'd8);
        reset = 1'b0;                         // between clock edges
        chk_rd("ra_count", 32'h8, 32'h0);
        chk_rd("ra_ctrl", 32'h0, 32'h0);
        chk("ra_irq", {31'b0, irq}, 32'h0);
        tick(1);
        reset = 1'b1;

        // ---------------- async reset while irq held ----------------
        wr(32'h4, 32'd1);
        wr(32'h0, 32'h9);                     // E0
        tick(4);
        chk("rb_irq_high", {31'b0, irq}, 32'h1);
        reset = 1'b0;
        #1;
        chk("rb_irq_drop", {31'b0, irq}, 32'h0);
        chk_rd("rb_preset", 32'h4, 32'h0);
        tick(1);
        reset = 1'b1;
        tick(2);
        chk("rb_irq_after", {31'b0, irq}, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
